// File: rtl/monsters_pkg.sv
// rtl/monsters_pkg.sv - shared slot/wave state types and stage sizing for the monster wave controller
package monsters_pkg;

    typedef enum logic [1:0] {
        INACTIVE  = 2'd0,
        ALIVE     = 2'd1,
        EXPLODING = 2'd2,
        DEAD      = 2'd3
    } slot_state_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        CLEARED = 2'd2
    } wave_state_t;

    function automatic int stage_amount(
        input logic [2:0] stage_num,
        input int         stage1_amount,
        input int         stage2_amount,
        input int         boss_amount,
        input int         total
    );
        int amt;
        case (stage_num)
            3'd1:    amt = stage1_amount;
            3'd2:    amt = stage2_amount;
            3'd4:    amt = boss_amount;
            default: amt = total;
        endcase
        return (amt > total) ? total : amt;
    endfunction

endpackage

// File: rtl/monster_slot.sv
// rtl/monster_slot.sv - one monster slot lifecycle FSM with explosion timer; HP counter under MONSTER_HP_EN
module monster_slot
    import monsters_pkg::*;
#(
    parameter int EXPLOSION_FRAMES = 10
`ifdef MONSTER_HP_EN
    ,
    parameter int HP_W = 3
`endif
) (
`ifdef MONSTER_HP_EN
    input  logic [HP_W-1:0] load_hp,
`endif
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic            load,
    input  logic            load_alive,
    input  logic            hit,
    output logic            is_alive,
    output logic            is_exploding,
    output logic            alive_next,
    output logic            kill
);

    localparam int CNT_W = (EXPLOSION_FRAMES > 1) ? $clog2(EXPLOSION_FRAMES) : 1;

    slot_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_hp;

`ifdef MONSTER_HP_EN
    logic [HP_W-1:0]    hp_q, hp_d;

    assign last_hp = (hp_q <= HP_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) hp_q <= '0;
        else       hp_q <= hp_d;
    end
`else
    assign last_hp = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INACTIVE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kill    = 1'b0;
`ifdef MONSTER_HP_EN
        hp_d    = hp_q;
`endif
        if (load) begin
            state_d = load_alive ? ALIVE : INACTIVE;
            cnt_d   = '0;
`ifdef MONSTER_HP_EN
            hp_d    = load_hp;
`endif
        end else begin
            case (state_q)
                ALIVE: begin
                    if (hit) begin
                        if (last_hp) begin
                            state_d = EXPLODING;
                            cnt_d   = '0;
                            kill    = 1'b1;
                        end
`ifdef MONSTER_HP_EN
                        else hp_d = hp_q - HP_W'(1);
`endif
                    end
                end
                EXPLODING: begin
                    if (tick) begin
                        if (cnt_q == CNT_W'(EXPLOSION_FRAMES - 1)) state_d = DEAD;
                        else                                       cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign is_alive     = (state_q == ALIVE);
    assign is_exploding = (state_q == EXPLODING);
    assign alive_next   = (state_d == ALIVE);

endmodule

// File: rtl/monster_wave_controller.sv
// rtl/monster_wave_controller.sv - wave sequencing, slot lifecycle masks and round-robin fire scheduling
// Optional per-slot hit points are enabled by defining MONSTER_HP_EN.
module monster_wave_controller
    import monsters_pkg::*;
#(
    parameter int MONSTER_AMOUNT   = 16,
    parameter int IDX_W            = (MONSTER_AMOUNT > 1) ? $clog2(MONSTER_AMOUNT) : 1,
    parameter int STAGE1_AMOUNT    = 4,
    parameter int STAGE2_AMOUNT    = 8,
    parameter int BOSS_AMOUNT      = 16,
    parameter int EXPLOSION_FRAMES = 10,
    parameter int SHOOT_COOLDOWN   = 60,
    parameter int HP_W             = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      startOfFrame,
    input  logic [2:0]                stage_num,
    input  logic                      wave_start,
    input  logic                      hit_valid,
    input  logic [IDX_W-1:0]          hit_index,
    output logic [MONSTER_AMOUNT-1:0] alive,
    output logic [MONSTER_AMOUNT-1:0] exploding,
    output logic [MONSTER_AMOUNT-1:0] shoot_pulse,
    output logic                      monster_died_pulse,
    output logic                      all_monsters_dead,
    output logic [IDX_W:0]            active_count,
    output logic [1:0]                wave_state
);

    localparam int CD_W = (SHOOT_COOLDOWN > 0) ? $clog2(SHOOT_COOLDOWN + 1) : 1;

    logic                      tick;
    int                        amount;
    logic [MONSTER_AMOUNT-1:0] hit_sel, load_alive, alive_d, kill, cand;
    logic [IDX_W:0]            count_d;
    wave_state_t               wave_q, wave_d;
    logic [CD_W-1:0]           cooldown_q;
    logic [IDX_W-1:0]          ptr_q, sel, sel_hi, sel_lo;
    logic                      found, found_hi, found_lo;

    assign tick   = startOfFrame & enable;
    assign amount = stage_amount(stage_num, STAGE1_AMOUNT, STAGE2_AMOUNT, BOSS_AMOUNT, MONSTER_AMOUNT);

`ifdef MONSTER_HP_EN
    logic [HP_W-1:0] hp_init;
    assign hp_init = (stage_num == 3'd4) ? {HP_W{1'b1}} : HP_W'(1);
`else
    localparam int hp_w_unused = HP_W;
`endif

    for (genvar i = 0; i < MONSTER_AMOUNT; i++) begin : g_slot
        // wave_start takes priority, so a simultaneous hit never reaches the slot
        assign hit_sel[i]    = hit_valid & ~wave_start & (hit_index == IDX_W'(i));
        assign load_alive[i] = (i < amount);

        monster_slot #(
            .EXPLOSION_FRAMES(EXPLOSION_FRAMES)
`ifdef MONSTER_HP_EN
            ,
            .HP_W(HP_W)
`endif
        ) u_slot (
`ifdef MONSTER_HP_EN
            .load_hp     (hp_init),
`endif
            .clk         (clk),
            .reset       (reset),
            .tick        (tick),
            .load        (wave_start),
            .load_alive  (load_alive[i]),
            .hit         (hit_sel[i]),
            .is_alive    (alive[i]),
            .is_exploding(exploding[i]),
            .alive_next  (alive_d[i]),
            .kill        (kill[i])
        );
    end

    // a slot being hit this cycle is not eligible to fire
    assign cand = alive & ~hit_sel;

    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        for (int j = 0; j < MONSTER_AMOUNT; j++) begin
            if (cand[j]) begin
                if (j > int'(ptr_q)) begin
                    if (!found_hi) begin
                        found_hi = 1'b1;
                        sel_hi   = IDX_W'(j);
                    end
                end else if (!found_lo) begin
                    found_lo = 1'b1;
                    sel_lo   = IDX_W'(j);
                end
            end
        end
    end

    assign found = found_hi | found_lo;
    assign sel   = found_hi ? sel_hi : sel_lo;

    always_comb begin
        count_d = '0;
        for (int j = 0; j < MONSTER_AMOUNT; j++) begin
            count_d = count_d + (IDX_W+1)'(alive_d[j]);
        end
    end

    always_comb begin
        wave_d = wave_q;
        if (wave_start)
            wave_d = ACTIVE;
        else if (wave_q == ACTIVE && !(|alive) && !(|exploding))
            wave_d = CLEARED;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wave_q             <= IDLE;
            all_monsters_dead  <= 1'b0;
            monster_died_pulse <= 1'b0;
            active_count       <= '0;
            shoot_pulse        <= '0;
            cooldown_q         <= CD_W'(SHOOT_COOLDOWN);
            ptr_q              <= IDX_W'(MONSTER_AMOUNT - 1);
        end else begin
            wave_q             <= wave_d;
            all_monsters_dead  <= (wave_d == CLEARED);
            monster_died_pulse <= |kill;
            active_count       <= count_d;
            shoot_pulse        <= '0;
            if (wave_start) begin
                cooldown_q <= CD_W'(SHOOT_COOLDOWN);
                ptr_q      <= IDX_W'(MONSTER_AMOUNT - 1);
            end else if (wave_q == ACTIVE) begin
                if (cooldown_q != '0) begin
                    if (tick) cooldown_q <= cooldown_q - CD_W'(1);
                end else if (found) begin
                    shoot_pulse <= MONSTER_AMOUNT'(1) << sel;
                    ptr_q       <= sel;
                    cooldown_q  <= CD_W'(SHOOT_COOLDOWN);
                end
            end
        end
    end

    assign wave_state = wave_q;

endmodule

// File: tb/tb_monster_wave_controller.sv
// tb/tb_monster_wave_controller.sv - self-checking bench for monster_wave_controller (either MONSTER_HP_EN build)
module tb_monster_wave_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        startOfFrame;
    logic [2:0]  stage_num;
    logic        wave_start;
    logic        hit_valid;
    logic [3:0]  hit_index;
    logic [15:0] alive;
    logic [15:0] exploding;
    logic [15:0] shoot_pulse;
    logic        monster_died_pulse;
    logic        all_monsters_dead;
    logic [4:0]  active_count;
    logic [1:0]  wave_state;

    int n_vec = 0;
    int n_err = 0;

    monster_wave_controller dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .startOfFrame      (startOfFrame),
        .stage_num         (stage_num),
        .wave_start        (wave_start),
        .hit_valid         (hit_valid),
        .hit_index         (hit_index),
        .alive             (alive),
        .exploding         (exploding),
        .shoot_pulse       (shoot_pulse),
        .monster_died_pulse(monster_died_pulse),
        .all_monsters_dead (all_monsters_dead),
        .active_count      (active_count),
        .wave_state        (wave_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ws;
        logic [2:0]  stage;
        logic        hv;
        logic [3:0]  hi;
        logic        sof;
        logic [15:0] e_alive;
        logic [15:0] e_expl;
        logic        e_died;
        logic [1:0]  e_wave;
        logic [4:0]  e_cnt;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) begin
            startOfFrame = 1'b1;
            cyc();
            startOfFrame = 1'b0;
            cyc();
        end
    endtask

    task automatic do_hit(input logic [3:0] idx);
        hit_valid = 1'b1;
        hit_index = idx;
        cyc();
        hit_valid = 1'b0;
    endtask

    task automatic do_start(input logic [2:0] stg);
        wave_start = 1'b1;
        stage_num  = stg;
        cyc();
        wave_start = 1'b0;
    endtask

    task automatic wait_shot(output logic [15:0] p, output int t);
        p = '0;
        t = 0;
        for (int k = 0; k < 200 && p == 16'h0; k++) begin
            startOfFrame = 1'b1;
            cyc();
            t++;
            startOfFrame = 1'b0;
            if (shoot_pulse != 16'h0) p = shoot_pulse;
            else begin
                cyc();
                if (shoot_pulse != 16'h0) p = shoot_pulse;
            end
        end
        startOfFrame = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [15:0] p;
        int          t;

        vecs[0]  = '{1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 16'h0000, 16'h0000, 1'b0, 2'd0, 5'd0};
        vecs[1]  = '{1'b1, 3'd1, 1'b0, 4'd0, 1'b0, 16'h000F, 16'h0000, 1'b0, 2'd1, 5'd4};
        vecs[2]  = '{1'b0, 3'd1, 1'b1, 4'd2, 1'b0, 16'h000B, 16'h0004, 1'b1, 2'd1, 5'd3};
        vecs[3]  = '{1'b0, 3'd1, 1'b0, 4'd0, 1'b1, 16'h000B, 16'h0004, 1'b0, 2'd1, 5'd3};
        vecs[4]  = '{1'b0, 3'd1, 1'b1, 4'd5, 1'b1, 16'h000B, 16'h0004, 1'b0, 2'd1, 5'd3};
        vecs[5]  = '{1'b0, 3'd1, 1'b1, 4'd2, 1'b0, 16'h000B, 16'h0004, 1'b0, 2'd1, 5'd3};
        vecs[6]  = '{1'b1, 3'd2, 1'b1, 4'd0, 1'b1, 16'h00FF, 16'h0000, 1'b0, 2'd1, 5'd8};
        vecs[7]  = '{1'b1, 3'd4, 1'b0, 4'd0, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 2'd1, 5'd16};
        vecs[8]  = '{1'b1, 3'd3, 1'b0, 4'd0, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 2'd1, 5'd16};
        vecs[9]  = '{1'b1, 3'd0, 1'b0, 4'd0, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 2'd1, 5'd16};
        vecs[10] = '{1'b1, 3'd1, 1'b0, 4'd0, 1'b0, 16'h000F, 16'h0000, 1'b0, 2'd1, 5'd4};

        reset        = 1'b1;
        enable       = 1'b1;
        startOfFrame = 1'b0;
        stage_num    = 3'd0;
        wave_start   = 1'b0;
        hit_valid    = 1'b0;
        hit_index    = 4'd0;
        @(negedge clk);
        @(negedge clk);
        chk("reset shoot_pulse", shoot_pulse, 16'h0);
        chk("reset all_dead", all_monsters_dead, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            wave_start   = vecs[i].ws;
            stage_num    = vecs[i].stage;
            hit_valid    = vecs[i].hv;
            hit_index    = vecs[i].hi;
            startOfFrame = vecs[i].sof;
            cyc();
            chk($sformatf("v%0d alive", i), alive, vecs[i].e_alive);
            chk($sformatf("v%0d exploding", i), exploding, vecs[i].e_expl);
            chk($sformatf("v%0d died", i), monster_died_pulse, vecs[i].e_died);
            chk($sformatf("v%0d wave_state", i), wave_state, vecs[i].e_wave);
            chk($sformatf("v%0d active_count", i), active_count, vecs[i].e_cnt);
            wave_start   = 1'b0;
            hit_valid    = 1'b0;
            startOfFrame = 1'b0;
        end

        // explosion lasts exactly 10 enabled ticks
        do_hit(4'd2);
        chk("expl start", exploding, 16'h0004);
        chk("expl died", monster_died_pulse, 1'b1);
        enable = 1'b0;
        tick_n(5);
        enable = 1'b1;
        tick_n(9);
        chk("expl after 9 ticks", exploding, 16'h0004);
        tick_n(1);
        chk("expl after 10 ticks", exploding, 16'h0000);
        chk("expl alive", alive, 16'h000B);

        // round-robin fire
        do_start(3'd1);
        wait_shot(p, t);
        chk("shot1 pulse", p, 16'h0001);
        chk("shot1 ticks", t, 60);
        wait_shot(p, t);
        chk("shot2 pulse", p, 16'h0002);
        chk("shot2 ticks", t, 60);

        do_start(3'd1);
        do_hit(4'd1);
        wait_shot(p, t);
        chk("skip shot1 pulse", p, 16'h0001);
        wait_shot(p, t);
        chk("skip shot2 pulse", p, 16'h0004);
        chk("skip shot2 ticks", t, 60);

        // clear wave
        do_start(3'd1);
        for (int k = 0; k < 4; k++) begin
            do_hit(4'(k));
            chk($sformatf("clear kill%0d died", k), monster_died_pulse, 1'b1);
        end
        tick_n(9);
        chk("clear early all_dead", all_monsters_dead, 1'b0);
        chk("clear early wave", wave_state, 2'd1);
        tick_n(1);
        chk("clear all_dead", all_monsters_dead, 1'b1);
        chk("clear wave", wave_state, 2'd2);
        chk("clear count", active_count, 5'd0);
        do_start(3'd4);
        chk("boss alive", alive, 16'hFFFF);
        chk("boss wave", wave_state, 2'd1);
        chk("boss all_dead", all_monsters_dead, 1'b0);
        chk("boss count", active_count, 5'd16);

`ifdef MONSTER_HP_EN
        for (int k = 1; k <= 6; k++) begin
            do_hit(4'd0);
            chk($sformatf("hp hit%0d alive0", k), alive[0], 1'b1);
            chk($sformatf("hp hit%0d died", k), monster_died_pulse, 1'b0);
        end
        do_hit(4'd0);
        chk("hp hit7 expl0", exploding[0], 1'b1);
        chk("hp hit7 died", monster_died_pulse, 1'b1);
`else
        do_hit(4'd0);
        chk("boss hit expl0", exploding[0], 1'b1);
        chk("boss hit alive0", alive[0], 1'b0);
        chk("boss hit died", monster_died_pulse, 1'b1);
`endif

        // asynchronous reset between clock edges
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async alive", alive, 16'h0);
        chk("async exploding", exploding, 16'h0);
        chk("async wave", wave_state, 2'd0);
        chk("async count", active_count, 5'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc();
        chk("post reset wave", wave_state, 2'd0);
        chk("post reset shoot", shoot_pulse, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/monster_wave_controller.md
Name: monster_wave_controller

Overview:
Parametrised successor to the fixed-count monster group logic. Holds per-slot lifecycle state for up to MONSTER_AMOUNT monsters: inactive, alive, exploding or dead. Sequences each wave from a stage number and schedules monster fire round-robin under a global cooldown. Sits between the collision resolver (which supplies the hit slot index) and the per-monster movement, drawing and missile instances, which consume its masks and pulses.

Parameters:
MONSTER_AMOUNT, 16, number of monster slots (1..32)
IDX_W, $clog2(MONSTER_AMOUNT), slot index width
STAGE1_AMOUNT, 4, active slots in stage 1
STAGE2_AMOUNT, 8, active slots in stage 2
BOSS_AMOUNT, 16, active slots in stage 4
EXPLOSION_FRAMES, 10, frames a slot stays in EXPLODING
SHOOT_COOLDOWN, 60, frames between successive shots
HP_W, 3, hit-point counter width (used only with MONSTER_HP_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  gates frame ticks (pause)
startOfFrame  in  1  one-cycle frame pulse
stage_num  in  3  stage selector, sampled on wave_start
wave_start  in  1  one-cycle pulse: load a new wave
hit_valid  in  1  a monster was hit this cycle
hit_index  in  IDX_W  slot that was hit
alive  out  MONSTER_AMOUNT  slot in ALIVE
exploding  out  MONSTER_AMOUNT  slot in EXPLODING
shoot_pulse  out  MONSTER_AMOUNT  one-hot, one-cycle fire command
monster_died_pulse  out  1  one-cycle pulse per kill
all_monsters_dead  out  1  wave cleared
active_count  out  IDX_W+1  number of slots in ALIVE
wave_state  out  2  IDLE=0, ACTIVE=1, CLEARED=2

Behaviour:
- tick = startOfFrame & enable. All frame counters advance only on tick.
- Reset: all slots INACTIVE, wave_state IDLE, all outputs 0, cooldown = SHOOT_COOLDOWN, round-robin pointer = MONSTER_AMOUNT-1.
- Stage amount: stage 1 -> STAGE1_AMOUNT, 2 -> STAGE2_AMOUNT, 4 -> BOSS_AMOUNT, any other value -> MONSTER_AMOUNT. The result is clamped to MONSTER_AMOUNT.
- wave_start, accepted in any wave state including ACTIVE:
  - next cycle, slots below the stage amount become ALIVE and the rest INACTIVE;
  - wave_state becomes ACTIVE; cooldown and pointer are reloaded.
- Slot FSM:
  - INACTIVE: left only via wave_start.
  - ALIVE -> EXPLODING: on a valid hit (hit_valid=1, hit_index<MONSTER_AMOUNT, slot ALIVE).
  - EXPLODING -> DEAD: after EXPLOSION_FRAMES ticks.
  - Hits on non-ALIVE slots or out-of-range indices are ignored.
- Hit latency: exploding[i] and monster_died_pulse both assert on the clock edge after hit_valid. At most one kill per cycle.
- Wave FSM: ACTIVE -> CLEARED when no slot is ALIVE or EXPLODING. all_monsters_dead = (wave_state==CLEARED), registered. CLEARED -> ACTIVE only on wave_start.
- Shooting, ACTIVE only:
  - cooldown decrements on tick while non-zero.
  - At 0: search slots pointer+1 .. with wrap-around for the first ALIVE slot. If found, pulse that bit of shoot_pulse for one cycle, set pointer to it and reload cooldown. If none, no pulse and cooldown holds at 0.
  - A slot hit in the same cycle as it is selected does not fire.
- active_count is registered and equals popcount(alive).
- hit_valid, tick and wave_start in the same cycle: wave_start wins; the hit is discarded.
- Asynchronous reset mid-wave: immediate return to reset values.

Optional Feature:
MONSTER_HP_EN
- Defined:
  - each slot has an HP_W-bit counter, loaded at wave_start with 1 for stages 1-2 and (1<<HP_W)-1 for stage 4;
  - a valid hit decrements it;
  - the slot enters EXPLODING only on the hit that makes the count 0;
  - monster_died_pulse fires only on that hit.
- Undefined: no HP storage; the first valid hit kills.

Decomposition:
- Package monsters_pkg holds:
  - enum slot_state_t {INACTIVE, ALIVE, EXPLODING, DEAD};
  - enum wave_state_t {IDLE, ACTIVE, CLEARED};
  - function stage_amount(stage_num).
- Sub-module monster_slot holds one slot's FSM, explosion frame counter and optional HP counter. It is generated MONSTER_AMOUNT times.
- Wave FSM, round-robin scheduler and pulse/count logic stay in the top module.

Test Plan:
- Reset, wave_start with stage_num=1 -> next cycle alive=0x000F, wave_state=1, active_count=4.
- hit_valid with hit_index=2 -> next cycle exploding=0x0004, monster_died_pulse high 1 cycle; 10 ticks later exploding=0.
- Stage 1 wave, run 60 ticks -> shoot_pulse=0x0001; after 60 more ticks shoot_pulse=0x0002; with slot 1 dead, the second pulse is 0x0004.
- Kill slots 0-3 and wait 10 ticks -> all_monsters_dead=1, wave_state=2. wave_start with stage_num=4 -> alive=0xFFFF.
- hit_valid at hit_index=5 during stage 1 (slot inactive), plus a second hit on an already-exploding slot -> no state change, no pulse.
- With MONSTER_HP_EN in stage 4: 6 hits on slot 0 -> still alive; 7th hit -> exploding and died pulse.
